// File: rtl/if_id_buffer_if.sv
// IF->ID buffer bus: fetch-side push port, decode-side pop port, flush and occupancy.
// A transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface if_id_buffer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             if_valid;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_instruction;
  logic             if_ready;
  logic             id_valid;
  logic [WIDTH-1:0] id_pc;
  logic [WIDTH-1:0] id_instruction;
  logic             id_ready;
  logic [CW-1:0]    occupancy;

  modport master (
    output flush, if_valid, if_pc, if_instruction, id_ready,
    input  if_ready, id_valid, id_pc, id_instruction, occupancy
  );

  modport slave (
    input  flush, if_valid, if_pc, if_instruction, id_ready,
    output if_ready, id_valid, id_pc, id_instruction, occupancy
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF->ID pipeline buffer: small circular FIFO of {pc, instruction} with branch flush.
// Output is registered storage only, so there is no combinational path from if_* to id_*.
module if_id_buffer #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic         clk,
  input  logic         rst,
  if_id_buffer_if.slave bus
);
  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam int unsigned   CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_pc    [DEPTH];
  logic [WIDTH-1:0] r_instr [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_if_ready;
  logic w_push;
  logic w_pop;

  assign w_full     = (r_count == FULL);
  assign w_empty    = (r_count == '0);
  // Full blocks push even if the head pops this cycle: keeps if_ready off the id_ready path.
  assign w_if_ready = ~w_full & ~bus.flush;
  assign w_push     = bus.if_valid & w_if_ready;
  assign w_pop      = ~w_empty & bus.id_ready & ~bus.flush;

  assign bus.if_ready       = w_if_ready;
  assign bus.id_valid       = ~w_empty;
  assign bus.id_pc          = w_empty ? '0  : r_pc[r_rd_ptr];
  assign bus.id_instruction = w_empty ? NOP : r_instr[r_rd_ptr];
  assign bus.occupancy      = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Writes are gated by push, so undriven fetch data while if_valid=0 never lands in storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= NOP;
      end
    end else if (w_push) begin
      r_pc[r_wr_ptr]    <= bus.if_pc;
      r_instr[r_wr_ptr] <= bus.if_instruction;
    end
  end
endmodule
